// File: rtl/collision_pkg.sv
// Shared types and widths for the sequential enemy/ball collision scanner.
package collision_pkg;

  // Screen coordinate width used by the ball and enemy position buses.
  localparam int COORD_W = 10;

  // Signed difference width: one extra bit so that BallX - circleX never wraps.
  localparam int DIFF_W = COORD_W + 1;

  // Width of the hit_index output bus (enough for up to 127 enemy slots).
  localparam int IDX_OUT_W = 7;

  // Scanner control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/collision_scanner_if.sv
// Bundle of the frame, ball, enemy and result signals exchanged between
// game_logic/ball (master side) and the collision scanner (slave side).
interface collision_scanner_if #(
  parameter int Enemies = 27
) ();
  import collision_pkg::*;

  logic                              vsync;
  logic                              level_active;
  logic [COORD_W-1:0]                BallX;
  logic [COORD_W-1:0]                BallY;
  logic [Enemies-1:0][COORD_W-1:0]   circleX;
  logic [Enemies-1:0][COORD_W-1:0]   circleY;
  logic [Enemies-1:0]                enable;
  logic                              clear_deaths;
  logic                              respawn;
  logic [IDX_OUT_W-1:0]              hit_index;
  logic [15:0]                       death_bcd;
  logic                              busy;

  modport master (
    output vsync, level_active, BallX, BallY, circleX, circleY, enable, clear_deaths,
    input  respawn, hit_index, death_bcd, busy
  );

  modport slave (
    input  vsync, level_active, BallX, BallY, circleX, circleY, enable, clear_deaths,
    output respawn, hit_index, death_bcd, busy
  );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter that saturates at 9999, with a synchronous clear
// that wins over a same-cycle increment.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        carry;
  logic [3:0]  digit;

  // Ripple increment from the units digit upward; 9999 holds instead of wrapping.
  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    digit   = 4'd0;
    if (clr) begin
      count_d = 16'h0000;
    end else if (inc && (count_q != 16'h9999)) begin
      carry = 1'b1;
      for (int d = 0; d < 4; d++) begin
        digit = count_q[d*4 +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            count_d[d*4 +: 4] = 4'd0;
          end else begin
            count_d[d*4 +: 4] = digit + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/collision_scanner.sv
// Sequential enemy/ball overlap checker: once per frame it walks the enemy
// slots one per clock, then raises a frame-wide respawn request and bumps the
// BCD death count when a hit lands outside the post-hit grace window.
module collision_scanner #(
  parameter int Enemies      = 27,
  parameter int HIT_R        = 9,
  parameter int GRACE_FRAMES = 30
) (
  input  logic                Clk,
  input  logic                Reset_n,
  collision_scanner_if.slave  bus
);
  import collision_pkg::*;

  localparam int IDX_W   = (Enemies > 1) ? $clog2(Enemies) : 1;
  localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(Enemies - 1);
  localparam logic [DIFF_W-1:0]  HIT_LIM   = DIFF_W'(HIT_R);
  localparam logic [GRACE_W-1:0] GRACE_MAX = GRACE_W'(GRACE_FRAMES);

  scan_state_e          state_q, state_d;
  logic                 vsync_q, vsync_d;
  logic [COORD_W-1:0]   ball_x_q, ball_x_d;
  logic [COORD_W-1:0]   ball_y_q, ball_y_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 hit_found_q, hit_found_d;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
  logic                 respawn_q, respawn_d;
  logic [IDX_OUT_W-1:0] hit_index_q, hit_index_d;
  logic [GRACE_W-1:0]   grace_q, grace_d;
  logic                 inc_deaths;
  logic                 tick;

  logic signed [DIFF_W-1:0] dx, dy;
  logic [DIFF_W-1:0]        adx, ady;
  logic                     slot_hit;
  logic [15:0]              death_bcd_w;

  // Overlap test for the slot under the scan index, done in signed arithmetic
  // so a ball near the screen edge cannot wrap into a false hit.
  always_comb begin
    dx       = $signed({1'b0, ball_x_q}) - $signed({1'b0, bus.circleX[idx_q]});
    dy       = $signed({1'b0, ball_y_q}) - $signed({1'b0, bus.circleY[idx_q]});
    adx      = dx[DIFF_W-1] ? $unsigned(-dx) : $unsigned(dx);
    ady      = dy[DIFF_W-1] ? $unsigned(-dy) : $unsigned(dy);
    slot_hit = bus.enable[idx_q] && (adx <= HIT_LIM) && (ady <= HIT_LIM);
  end

  // Next-state and datapath updates for the IDLE -> SCAN -> DONE frame cycle.
  always_comb begin
    state_d     = state_q;
    vsync_d     = bus.vsync;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    idx_d       = idx_q;
    hit_found_d = hit_found_q;
    hit_idx_d   = hit_idx_q;
    respawn_d   = respawn_q;
    hit_index_d = hit_index_q;
    grace_d     = grace_q;
    inc_deaths  = 1'b0;
    tick        = bus.vsync & ~vsync_q;

    case (state_q)
      IDLE: begin
        if (tick) begin
          hit_found_d = 1'b0;
          if (bus.level_active) begin
            state_d  = SCAN;
            ball_x_d = bus.BallX;
            ball_y_d = bus.BallY;
            idx_d    = '0;
          end else begin
            state_d = DONE;
          end
        end
      end

      SCAN: begin
        if (slot_hit && !hit_found_q) begin
          hit_found_d = 1'b1;
          hit_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (hit_found_q && (grace_q == '0)) begin
          respawn_d   = 1'b1;
          hit_index_d = IDX_OUT_W'(hit_idx_q);
          inc_deaths  = 1'b1;
          grace_d     = GRACE_MAX;
        end else begin
          respawn_d = 1'b0;
          if (grace_q != '0) begin
            grace_d = grace_q - 1'b1;
          end
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan datapath and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vsync_q     <= 1'b0;
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      idx_q       <= '0;
      hit_found_q <= 1'b0;
      hit_idx_q   <= '0;
      respawn_q   <= 1'b0;
      hit_index_q <= '0;
      grace_q     <= '0;
    end else begin
      vsync_q     <= vsync_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      idx_q       <= idx_d;
      hit_found_q <= hit_found_d;
      hit_idx_q   <= hit_idx_d;
      respawn_q   <= respawn_d;
      hit_index_q <= hit_index_d;
      grace_q     <= grace_d;
    end
  end

  bcd_counter4 u_deaths (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (bus.clear_deaths),
    .inc   (inc_deaths),
    .count (death_bcd_w)
  );

  assign bus.respawn   = respawn_q;
  assign bus.hit_index = hit_index_q;
  assign bus.death_bcd = death_bcd_w;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: a frame-level model predicts respawn,
// hit_index, death count and busy, and is compared against the DUT each cycle.
module tb_collision_scanner;

  logic Clk;
  logic Reset_n;

  int checks;
  int errors;
  bit cmp_on;

  int ex [27];
  int ey [27];
  bit en [27];
  int ball_x;
  int ball_y;
  bit level_on;

  bit m_respawn;
  bit m_busy;
  int m_hit_index;
  int m_deaths;
  int m_grace;
  int m2_deaths;

  collision_scanner_if #(.Enemies(27)) bus ();
  collision_scanner_if #(.Enemies(2))  bus2 ();

  collision_scanner #(.Enemies(27), .HIT_R(9), .GRACE_FRAMES(30)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  collision_scanner #(.Enemies(2), .HIT_R(9), .GRACE_FRAMES(0)) dut2 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus2)
  );

  initial Clk = 1'b0;
  // 10-unit clock period.
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic logic [15:0] toBcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  // Lowest enabled enemy within the +/-9 pixel window of the ball, or -1.
  function automatic int firstHit();
    int dx;
    int dy;
    for (int i = 0; i < 27; i++) begin
      dx = ball_x - ex[i];
      dy = ball_y - ey[i];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (en[i] && dx <= 9 && dy <= 9) return i;
    end
    return -1;
  endfunction

  task automatic applyStimulus();
    for (int i = 0; i < 27; i++) begin
      bus.circleX[i] = 10'(ex[i]);
      bus.circleY[i] = 10'(ey[i]);
      bus.enable[i]  = en[i];
    end
    bus.BallX        = 10'(ball_x);
    bus.BallY        = 10'(ball_y);
    bus.level_active = level_on;
  endtask

  task automatic clearEnemies();
    for (int i = 0; i < 27; i++) begin
      ex[i] = 500;
      ey[i] = 500;
      en[i] = 1'b0;
    end
  endtask

  // One frame: tick, scan (if active), DONE, then the model applies the frame result.
  task automatic runFrame(input bit active, input bit clr_at_done, input bit drop_mid);
    int hit;
    level_on = active;
    applyStimulus();
    @(posedge Clk); #1;
    hit = active ? firstHit() : -1;
    bus.vsync = 1'b1;
    @(posedge Clk); #1;
    bus.vsync = 1'b0;
    m_busy = 1'b1;
    if (drop_mid) bus.level_active = 1'b0;
    if (active) begin
      repeat (27) @(posedge Clk);
      #1;
    end
    bus.clear_deaths = clr_at_done;
    @(posedge Clk); #1;
    bus.clear_deaths = 1'b0;
    m_busy = 1'b0;
    if (hit >= 0 && m_grace == 0) begin
      m_respawn   = 1'b1;
      m_hit_index = hit;
      m_deaths    = (m_deaths < 9999) ? m_deaths + 1 : 9999;
      m_grace     = 30;
    end else begin
      m_respawn = 1'b0;
      if (m_grace > 0) m_grace--;
    end
    if (clr_at_done) m_deaths = 0;
  endtask

  task automatic burn(input int n);
    for (int k = 0; k < n; k++) runFrame(1'b0, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison of the main DUT against the frame model.
  always @(negedge Clk) begin
    if (cmp_on) begin
      checkOutput("respawn", 32'(bus.respawn), 32'(m_respawn));
      checkOutput("hit_index", 32'(bus.hit_index), 32'(m_hit_index));
      checkOutput("death_bcd", 32'(bus.death_bcd), 32'(toBcd(m_deaths)));
      checkOutput("busy", 32'(bus.busy), 32'(m_busy));
    end
  end

  // Run-length guard so the bench always reaches its summary.
  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    checks = 0; errors = 0; cmp_on = 1'b0;
    m_respawn = 1'b0; m_busy = 1'b0; m_hit_index = 0; m_deaths = 0; m_grace = 0; m2_deaths = 0;
    clearEnemies();
    ball_x = 0; ball_y = 0; level_on = 1'b0;
    applyStimulus();
    bus.vsync = 1'b0;
    bus.clear_deaths = 1'b0;
    bus2.vsync = 1'b0;
    bus2.clear_deaths = 1'b0;
    bus2.level_active = 1'b1;
    bus2.BallX = 10'd50;
    bus2.BallY = 10'd50;
    bus2.circleX[0] = 10'd50;
    bus2.circleY[0] = 10'd50;
    bus2.circleX[1] = 10'd900;
    bus2.circleY[1] = 10'd900;
    bus2.enable = 2'b01;

    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("reset_respawn", 32'(bus.respawn), 32'd0);
    checkOutput("reset_hit_index", 32'(bus.hit_index), 32'd0);
    checkOutput("reset_death_bcd", 32'(bus.death_bcd), 32'h0000);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    #20 Reset_n = 1'b1;
    cmp_on = 1'b1;

    // Single overlapping enemy in slot 5.
    ball_x = 100; ball_y = 100;
    ex[5] = 105; ey[5] = 95; en[5] = 1'b1;
    runFrame(1'b1, 1'b0, 1'b0);
    checkOutput("t1_respawn", 32'(bus.respawn), 32'd1);
    checkOutput("t1_hit_index", 32'(bus.hit_index), 32'd5);
    checkOutput("t1_death_bcd", 32'(bus.death_bcd), 32'h0001);
    en[5] = 1'b0;
    runFrame(1'b1, 1'b0, 1'b0);
    checkOutput("t1_respawn_drop", 32'(bus.respawn), 32'd0);
    checkOutput("t1_death_hold", 32'(bus.death_bcd), 32'h0001);
    burn(29);

    // Near the origin: a negative difference must not wrap.
    clearEnemies();
    ball_x = 4; ball_y = 4;
    ex[0] = 12; ey[0] = 0; en[0] = 1'b1;
    runFrame(1'b1, 1'b0, 1'b0);
    checkOutput("t2_respawn", 32'(bus.respawn), 32'd1);
    checkOutput("t2_hit_index", 32'(bus.hit_index), 32'd0);
    checkOutput("t2_death_bcd", 32'(bus.death_bcd), 32'h0002);
    burn(30);
    ex[0] = 14;
    runFrame(1'b1, 1'b0, 1'b0);
    checkOutput("t2_miss_respawn", 32'(bus.respawn), 32'd0);
    checkOutput("t2_miss_death", 32'(bus.death_bcd), 32'h0002);

    // Two overlapping slots (3 at the exact window edge), one just outside; level drops mid-scan.
    clearEnemies();
    ball_x = 200; ball_y = 300;
    ex[2] = 190; ey[2] = 300; en[2] = 1'b1;
    ex[3] = 191; ey[3] = 309; en[3] = 1'b1;
    ex[7] = 200; ey[7] = 300; en[7] = 1'b1;
    runFrame(1'b1, 1'b0, 1'b1);
    checkOutput("t3_respawn", 32'(bus.respawn), 32'd1);
    checkOutput("t3_hit_index", 32'(bus.hit_index), 32'd3);
    checkOutput("t3_death_bcd", 32'(bus.death_bcd), 32'h0003);

    // Grace window: 30 overlapping frames ignored, the 31st counts.
    repeat (30) runFrame(1'b1, 1'b0, 1'b0);
    checkOutput("t4_grace_respawn", 32'(bus.respawn), 32'd0);
    checkOutput("t4_grace_death", 32'(bus.death_bcd), 32'h0003);
    runFrame(1'b1, 1'b0, 1'b0);
    checkOutput("t4_after_respawn", 32'(bus.respawn), 32'd1);
    checkOutput("t4_after_death", 32'(bus.death_bcd), 32'h0004);

    // Level inactive with an overlapping enemy and no grace left.
    burn(30);
    runFrame(1'b0, 1'b0, 1'b0);
    checkOutput("t5_respawn", 32'(bus.respawn), 32'd0);
    checkOutput("t5_death_bcd", 32'(bus.death_bcd), 32'h0004);

    // Clear in the same cycle as a counting DONE.
    runFrame(1'b1, 1'b1, 1'b0);
    checkOutput("t6_respawn", 32'(bus.respawn), 32'd1);
    checkOutput("t6_death_bcd", 32'(bus.death_bcd), 32'h0000);

    // Reset pulse while the scan sits at index 10.
    level_on = 1'b1;
    applyStimulus();
    @(posedge Clk); #1;
    bus.vsync = 1'b1;
    @(posedge Clk); #1;
    bus.vsync = 1'b0;
    m_busy = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    m_respawn = 1'b0; m_hit_index = 0; m_deaths = 0; m_grace = 0; m_busy = 1'b0;
    #1;
    checkOutput("t7_busy", 32'(bus.busy), 32'd0);
    checkOutput("t7_respawn", 32'(bus.respawn), 32'd0);
    checkOutput("t7_hit_index", 32'(bus.hit_index), 32'd0);
    @(posedge Clk); #3;
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    runFrame(1'b1, 1'b0, 1'b0);
    checkOutput("t7_recover_death", 32'(bus.death_bcd), 32'h0001);

    // Counter boundaries on the small no-grace instance: one hit per 4-cycle frame.
    @(posedge Clk); #1;
    for (int n = 1; n <= 10000; n++) begin
      bus2.vsync = 1'b1;
      @(posedge Clk); #1;
      bus2.vsync = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      m2_deaths = (m2_deaths < 9999) ? m2_deaths + 1 : 9999;
      checkOutput("cnt_model", 32'(bus2.death_bcd), 32'(toBcd(m2_deaths)));
      if (n == 999)   checkOutput("cnt_0999", 32'(bus2.death_bcd), 32'h0999);
      if (n == 1000)  checkOutput("cnt_1000", 32'(bus2.death_bcd), 32'h1000);
      if (n == 10000) checkOutput("cnt_sat", 32'(bus2.death_bcd), 32'h9999);
    end
    bus2.clear_deaths = 1'b1;
    @(posedge Clk); #1;
    bus2.clear_deaths = 1'b0;
    m2_deaths = 0;
    checkOutput("cnt_clear", 32'(bus2.death_bcd), 32'h0000);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
